shift_add_multiplier: RTL and testbench



---
 rtl/shift_add_multiplier_if.sv | 13 +
 rtl/shift_add_multiplier.sv | 58 +++++
 tb/tb_shift_add_multiplier.sv | 138 +++++++++++++
 3 files changed

// File: rtl/shift_add_multiplier_if.sv
// shift_add_multiplier_if: load/start strobes, operand bus and product/status bundle
interface shift_add_multiplier_if #(parameter int WIDTH = 8);
    logic               LDA;
    logic               LDQ;
    logic               MULT_EN;
    logic [WIDTH-1:0]   D_IN;
    logic [2*WIDTH-1:0] PRODUCT;
    logic               BUSY;
    logic               DONE;
    logic               Z_FLAG;
    modport master (output LDA, LDQ, MULT_EN, D_IN, input PRODUCT, BUSY, DONE, Z_FLAG);
    modport slave (input LDA, LDQ, MULT_EN, D_IN, output PRODUCT, BUSY, DONE, Z_FLAG);
endinterface

// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential unsigned shift-add multiplier, one partial product per clock
module shift_add_multiplier #(
    parameter int WIDTH = 8
) (
    input logic                   CLK,
    input logic                   RST,
    shift_add_multiplier_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2;
    logic [1:0]         state;
    logic [WIDTH-1:0]   m, q, a;
    logic [CW-1:0]      cnt;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] product;
    logic               z;
    // sum[WIDTH] is the step carry; shifting {sum,q} right drops it into a and clears it
    always_comb sum = {1'b0, a} + {1'b0, q[0] ? m : '0};
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            m       <= '0;
            q       <= '0;
            a       <= '0;
            cnt     <= '0;
            product <= '0;
            z       <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.MULT_EN) begin
                        a     <= '0;
                        cnt   <= '0;
                        state <= RUN;
                    end else begin
                        if (bus.LDA) m <= bus.D_IN;
                        if (bus.LDQ) q <= bus.D_IN;
                    end
                end
                RUN: begin
                    a   <= sum[WIDTH:1];
                    q   <= {sum[0], q[WIDTH-1:1]};
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        state   <= FIN;
                        product <= {sum, q[WIDTH-1:1]};
                        z       <= ~|{sum, q[WIDTH-1:1]};
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign bus.PRODUCT = product;
    assign bus.Z_FLAG  = z;
    assign bus.BUSY    = state == RUN;
    assign bus.DONE    = state == FIN;
endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb_shift_add_multiplier: directed and random multiplies against an arithmetic reference model
module tb_shift_add_multiplier;
    localparam int W = 8;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    int tests = 0;
    int fails = 0;
    logic [W-1:0]   m_ref, q_ref;
    logic [2*W-1:0] p_ref;
    shift_add_multiplier_if #(.WIDTH(W)) bus ();
    shift_add_multiplier #(.WIDTH(W)) dut (.CLK(CLK), .RST(RST), .bus(bus));
    always #5 CLK = ~CLK;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask
    task automatic load(input logic a, input logic q, input logic [W-1:0] v);
        bus.LDA = a;
        bus.LDQ = q;
        bus.D_IN = v;
        tick();
        bus.LDA = 1'b0;
        bus.LDQ = 1'b0;
        if (a) m_ref = v;
        if (q) q_ref = v;
    endtask
    task automatic check_idle(input string tag);
        check({tag, "_busy"}, 32'(bus.BUSY), 0);
        check({tag, "_done"}, 32'(bus.DONE), 0);
        check({tag, "_prod"}, 32'(bus.PRODUCT), 32'(p_ref));
        check({tag, "_z"}, 32'(bus.Z_FLAG), 32'(p_ref == 0));
    endtask
    // mode 0 plain, 1 strobes during RUN, 2 reset at RUN cycle 4, 3 LDA together with start
    task automatic run(input string tag, input int mode);
        int n = 0;
        bus.MULT_EN = 1'b1;
        if (mode == 3) begin
            bus.LDA = 1'b1;
            bus.D_IN = 8'd9;
        end
        tick();
        bus.MULT_EN = 1'b0;
        bus.LDA = 1'b0;
        while (bus.BUSY && n < 20) begin
            if (bus.DONE) check({tag, "_overlap"}, 1, 0);
            if (bus.PRODUCT !== p_ref) check({tag, "_hold"}, 32'(bus.PRODUCT), 32'(p_ref));
            if (mode == 2 && n == 4) begin
                RST = 1'b1;
                tick();
                RST = 1'b0;
                m_ref = '0;
                q_ref = '0;
                p_ref = '0;
                check_idle({tag, "_rst"});
                for (int i = 0; i < W + 2; i++) begin
                    if (bus.DONE || bus.BUSY) check({tag, "_ghost"}, 1, 0);
                    tick();
                end
                return;
            end
            bus.MULT_EN = mode == 1 && n == 1;
            bus.LDA = mode == 1 && n == 2;
            bus.LDQ = mode == 1 && n == 3;
            bus.D_IN = n == 2 ? 8'd99 : 8'd77;
            tick();
            bus.MULT_EN = 1'b0;
            bus.LDA = 1'b0;
            bus.LDQ = 1'b0;
            n++;
        end
        p_ref = m_ref * q_ref;
        q_ref = p_ref[W-1:0];
        check({tag, "_busylen"}, 32'(n), W);
        check({tag, "_done"}, 32'(bus.DONE), 1);
        check({tag, "_prod"}, 32'(bus.PRODUCT), 32'(p_ref));
        check({tag, "_z"}, 32'(bus.Z_FLAG), 32'(p_ref == 0));
        tick();
        check_idle({tag, "_after"});
    endtask
    initial begin
        bus.LDA = 1'b0;
        bus.LDQ = 1'b0;
        bus.MULT_EN = 1'b0;
        bus.D_IN = '0;
        m_ref = '0;
        q_ref = '0;
        p_ref = '0;
        tick();
        tick();
        RST = 1'b0;
        check_idle("reset");
        load(1, 0, 13);
        load(0, 1, 11);
        run("basic", 0);
        load(1, 1, 255);
        run("max", 0);
        load(0, 1, 1);
        run("reuse_m", 0);
        load(1, 0, 0);
        load(0, 1, 200);
        run("zero", 0);
        tick();
        check_idle("zero_hold");
        load(1, 0, 13);
        load(0, 1, 11);
        run("ignored", 1);
        load(0, 1, 1);
        run("m_kept", 0);
        load(1, 0, 13);
        load(0, 1, 11);
        run("midrst", 2);
        load(1, 0, 13);
        load(0, 1, 11);
        run("fresh", 0);
        load(1, 0, 5);
        load(0, 1, 3);
        run("ld_start", 3);
        for (int k = 0; k < 30; k++) begin
            int sel = $urandom_range(0, 3);
            if (sel == 0) load(1, 1, W'($urandom));
            else begin
                if (sel != 2) load(1, 0, W'($urandom));
                load(0, 1, W'($urandom));
            end
            if ($urandom_range(0, 1) == 1) tick();
            run("rand", 0);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
